// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned PC_W        = 16;
  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Generic enable register with synchronous active-high reset; holds the fetch PC.
module fetch_unit_pc_reg #(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the multi-cycle imem, buffers a
// fetched word across stalls, applies redirects and stops on HALT.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] instruction,
  output logic [15:0] currPC,
  output logic [15:0] pc_plus_2,
  output logic        instr_valid,
  output logic        halted
);

  fetch_state_t state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic [15:0]     buf_instr;
  logic [15:0]     word;
  logic            halted_q;
  logic            deliver;
  logic            advance;
  logic            pc_en;

  // A word is delivered when it leaves toward decode this cycle; a delivered
  // HALT freezes the PC instead of advancing it.
  always_comb begin
    pc_inc  = pc + 16'd2;
    word    = (state == HOLD) ? buf_instr : imem_data;
    deliver = !redirect && !stall &&
              (((state == FETCH) && imem_done) || (state == HOLD));
    advance = deliver && !is_halt(word);
    pc_en   = advance || redirect;
    pc_next = redirect ? redirect_pc : pc_inc;
  end

  fetch_unit_pc_reg #(
    .WIDTH     (PC_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_next),
    .q   (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      buf_instr <= NOP_INSTR;
      halted_q  <= 1'b0;
    end else if (redirect) begin
      state     <= FETCH;
      buf_instr <= NOP_INSTR;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_done) begin
            if (stall) begin
              buf_instr <= imem_data;
              state     <= HOLD;
            end else if (is_halt(imem_data)) begin
              state    <= HALTED;
              halted_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if (is_halt(buf_instr)) begin
              state    <= HALTED;
              halted_q <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALTED: ;
        default: state <= FETCH;
      endcase
    end
  end

  // Redirect flushes the current cycle and drops imem_rd to abort the access.
  always_comb begin
    imem_rd     = 1'b0;
    instruction = NOP_INSTR;
    instr_valid = 1'b0;
    if (!redirect) begin
      case (state)
        FETCH: begin
          imem_rd = 1'b1;
          if (imem_done) begin
            instruction = imem_data;
            instr_valid = 1'b1;
          end
        end
        HOLD: begin
          instruction = buf_instr;
          instr_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign currPC    = pc;
  assign pc_plus_2 = pc_inc;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic
// against a delivery-level reference model.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic [15:0] instruction;
  logic [15:0] currPC;
  logic [15:0] pc_plus_2;
  logic        instr_valid;
  logic        halted;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: PC, an optional held word, and a halted flag.
  logic [15:0] m_pc;
  logic [15:0] m_buf;
  logic        m_hold;
  logic        m_halted;
  logic [15:0] halt_a = 16'h0010;
  logic [15:0] halt_b = 16'h0080;

  fetch_unit #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_done   (imem_done),
    .instruction (instruction),
    .currPC      (currPC),
    .pc_plus_2   (pc_plus_2),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memword(input logic [15:0] a);
    logic [15:0] w;
    if (a == halt_a || a == halt_b) return 16'h0000;
    w = a * 16'h003B + 16'h1234;
    w[11] = 1'b1;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs at posedge+1, check at negedge, advance model.
  task automatic cycle(input logic s, input logic d, input logic r, input logic [15:0] rp);
    logic [15:0] data;
    logic [15:0] e_instr;
    logic [15:0] word;
    logic        e_rd;
    logic        e_valid;
    stall = s; imem_done = d; redirect = r; redirect_pc = rp;
    data = memword(m_pc);
    imem_data = data;
    #4;
    e_rd = 1'b0; e_valid = 1'b0; e_instr = NOP;
    if (!r && !m_halted) begin
      if (m_hold) begin
        e_valid = 1'b1; e_instr = m_buf;
      end else begin
        e_rd = 1'b1;
        if (d) begin e_valid = 1'b1; e_instr = data; end
      end
    end
    if (!rst) begin
      chk("imem_rd", {15'd0, imem_rd}, {15'd0, e_rd});
      chk("imem_addr", imem_addr, m_pc);
      chk("instruction", instruction, e_instr);
      chk("instr_valid", {15'd0, instr_valid}, {15'd0, e_valid});
      chk("currPC", currPC, m_pc);
      chk("pc_plus_2", pc_plus_2, m_pc + 16'd2);
      chk("halted", {15'd0, halted}, {15'd0, m_halted});
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = 16'h0000; m_hold = 1'b0; m_halted = 1'b0; m_buf = NOP;
    end else if (r) begin
      m_pc = rp; m_hold = 1'b0; m_halted = 1'b0; m_buf = NOP;
    end else if (!m_halted && (m_hold || d)) begin
      word = m_hold ? m_buf : data;
      if (s) begin
        m_hold = 1'b1; m_buf = word;
      end else begin
        m_hold = 1'b0;
        if (word[15:11] == 5'b00000) m_halted = 1'b1;
        else m_pc = m_pc + 16'd2;
      end
    end
  endtask

  task automatic do_reset(input logic s, input logic d);
    rst = 1'b1;
    cycle(s, d, 1'b0, 16'h0000);
    rst = 1'b0;
  endtask

  initial begin
    logic        s, d, r;
    logic [15:0] rp;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_done = 1'b0; imem_data = '0;
    m_pc = '0; m_buf = NOP; m_hold = 1'b0; m_halted = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);
    chk("reset_pc", currPC, 16'h0000);
    chk("reset_halted", {15'd0, halted}, 16'd0);

    // Zero-wait memory: 0x0000, 0x0002, 0x0004 back to back.
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("zw_pc1", currPC, 16'h0002);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("zw_pc2", currPC, 16'h0004);
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Three-cycle latency.
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("lat_pc_hold", currPC, 16'h0006);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("lat_pc_adv", currPC, 16'h0008);

    // Done under stall, held for three cycles, then released.
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    chk("hold_pc", currPC, 16'h0008);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("hold_release_pc", currPC, 16'h000A);

    // Redirect with a request outstanding, then during HOLD.
    cycle(1'b0, 1'b0, 1'b1, 16'h0100);
    chk("redir_pc", currPC, 16'h0100);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, 16'h0100);
    cycle(1'b0, 1'b1, 1'b0, '0);

    // HALT at 0x0010, then resume via redirect.
    cycle(1'b0, 1'b0, 1'b1, 16'h0010);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("halt_flag", {15'd0, halted}, 16'd1);
    chk("halt_pc", currPC, 16'h0010);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0020);
    chk("resume_halted", {15'd0, halted}, 16'd0);
    chk("resume_pc", currPC, 16'h0020);
    cycle(1'b0, 1'b1, 1'b0, '0);

    // PC wrap and odd redirect target.
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFE);
    chk("wrap_plus2", pc_plus_2, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("wrap_pc", currPC, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 16'h0101);
    chk("odd_pc", currPC, 16'h0101);
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Reset in the middle of HOLD.
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    do_reset(1'b1, 1'b1);
    chk("rst_hold_pc", currPC, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 800; i++) begin
      s = ($urandom_range(0, 9) < 3);
      d = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 99) < 6);
      rp = 16'($urandom);
      if ($urandom_range(0, 3) != 0) rp[0] = 1'b0;
      if ($urandom_range(0, 2) == 0) rp = 16'h0070 + 16'($urandom_range(0, 8) * 2);
      if ($urandom_range(0, 99) == 0) do_reset(s, d);
      else cycle(s, d, r, rp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
